// File: rtl/mem_wb_unit.sv
// mem_wb_unit: memory access and writeback stage of the multicycle datapath.
//
// Accepts one execute result per transaction, performs a load or store over a
// req/done memory handshake when the instruction needs one, then issues a
// single-cycle register writeback. HALT and ERR are terminal until rst.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   -> a load/store to an odd address goes straight to ERR
//   undefined -> addresses pass through unchanged
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ex_*               execute result bus (ex_valid / ex_ready handshake)
//   mem_*              memory request: mem_en held until mem_done
//   wb_*               one-cycle register writeback strobe and payload
//   halted, err        terminal state indications

module mem_wb_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [15:0] ex_out,
  input  logic [15:0] ex_wrdata,
  input  logic [15:0] ex_pc2,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_regwrite,
  input  logic [1:0]  ex_wbsel,
  input  logic [2:0]  ex_wreg,
  input  logic        ex_halt,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [2:0]  wb_reg,
  output logic [15:0] wb_data,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [15:0] out_q;
  logic [15:0] wrdata_q;
  logic [15:0] pc2_q;
  logic        wr_q;
  logic        regwrite_q;
  logic        halt_q;
  logic [1:0]  wbsel_q;
  logic [2:0]  wreg_q;
  logic        bad_align;

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_align = ex_out[0];
`else
  assign bad_align = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_q      <= '0;
      wrdata_q   <= '0;
      pc2_q      <= '0;
      wr_q       <= 1'b0;
      regwrite_q <= 1'b0;
      halt_q     <= 1'b0;
      wbsel_q    <= '0;
      wreg_q     <= '0;
      wb_reg     <= '0;
      wb_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            out_q      <= ex_out;
            wrdata_q   <= ex_wrdata;
            pc2_q      <= ex_pc2;
            wr_q       <= ex_memwrite;
            regwrite_q <= ex_regwrite;
            halt_q     <= ex_halt;
            wbsel_q    <= ex_wbsel;
            wreg_q     <= ex_wreg;
            cnt        <= '0;
            if (ex_memread && ex_memwrite) begin
              state <= S_ERR;
            end else if (ex_wbsel == 2'b11) begin
              state <= S_ERR;
            end else if ((ex_memread || ex_memwrite) && bad_align) begin
              state <= S_ERR;
            end else if (ex_memread || ex_memwrite) begin
              state <= S_ACCESS;
            end else begin
              // No memory access: writeback payload is known now. A memory
              // source without a load has no data, so it writes zero.
              state  <= S_WB;
              wb_reg <= ex_wreg;
              case (ex_wbsel)
                2'b10:   wb_data <= ex_pc2;
                2'b01:   wb_data <= '0;
                default: wb_data <= ex_out;
              endcase
            end
          end
        end
        S_ACCESS: begin
          cnt <= cnt + 8'd1;
          // done wins over timeout when both land in the last cycle
          if (mem_done) begin
            state  <= S_WB;
            wb_reg <= wreg_q;
            case (wbsel_q)
              2'b01:   wb_data <= mem_rdata;
              2'b10:   wb_data <= pc2_q;
              default: wb_data <= out_q;
            endcase
          end else if (cnt == CNT_LAST) begin
            state <= S_ERR;
          end
        end
        S_WB: begin
          state <= halt_q ? S_HALT : S_IDLE;
        end
        S_HALT:  state <= S_HALT;
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ex_ready  = (state == S_IDLE);
  assign mem_en    = (state == S_ACCESS);
  assign mem_wr    = (state == S_ACCESS) && wr_q;
  assign mem_addr  = out_q;
  assign mem_wdata = wrdata_q;
  assign wb_valid  = (state == S_WB);
  assign wb_we     = (state == S_WB) && regwrite_q;
  assign halted    = (state == S_HALT);
  assign err       = (state == S_ERR);

endmodule

// File: tb/tb_mem_wb_unit.sv
module tb_mem_wb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [15:0] ex_out = '0, ex_wrdata = '0, ex_pc2 = '0;
  logic        ex_memread = 1'b0, ex_memwrite = 1'b0, ex_regwrite = 1'b0;
  logic [1:0]  ex_wbsel = '0;
  logic [2:0]  ex_wreg = '0;
  logic        ex_halt = 1'b0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic        wb_valid, wb_we;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        halted, err;

  int errors = 0;
  int checks = 0;

  mem_wb_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_out(ex_out), .ex_wrdata(ex_wrdata), .ex_pc2(ex_pc2),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_wbsel(ex_wbsel), .ex_wreg(ex_wreg), .ex_halt(ex_halt),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [2:0]  wreg;
    logic [15:0] data;
  } wb_t;

  typedef struct {
    string       name;
    logic        rd, wr, rw, halt;
    logic [1:0]  wbsel;
    logic [2:0]  wreg;
    logic [15:0] out, wrdata, pc2, rdata;
    int          done_at;   // ACCESS cycle (1-based) that sees mem_done; 0 = never
    int          exp_mem;   // expected number of mem_en cycles
    logic        exp_err;
    logic        exp_we;
    logic [15:0] exp_data;
  } vec_t;

  wb_t  exp_q[$];
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Writeback scoreboard: every wb_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got reg=%0d data=0x%0h expected no writeback", wb_reg, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_we", {31'b0, wb_we}, {31'b0, e.we});
        check("wb_reg", {29'b0, wb_reg}, {29'b0, e.wreg});
        check("wb_data", {16'b0, wb_data}, {16'b0, e.data});
      end
    end
  end

  function automatic vec_t mk(string nm, logic rd, logic wr, logic rw, logic halt,
                              logic [1:0] wbsel, logic [2:0] wreg, logic [15:0] out,
                              logic [15:0] wrdata, logic [15:0] pc2, logic [15:0] rdata,
                              int done_at, int exp_mem, logic exp_err, logic exp_we,
                              logic [15:0] exp_data);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.rw = rw; v.halt = halt;
    v.wbsel = wbsel; v.wreg = wreg; v.out = out; v.wrdata = wrdata; v.pc2 = pc2;
    v.rdata = rdata; v.done_at = done_at; v.exp_mem = exp_mem; v.exp_err = exp_err;
    v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    check("rst_outputs", {27'b0, mem_en, mem_wr, wb_valid, halted, err}, 32'd0);
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0; ex_regwrite = 1'b0;
    ex_halt = 1'b0; ex_wbsel = '0; ex_wreg = '0; ex_out = '0; ex_wrdata = '0; ex_pc2 = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int bad;
    int guard;
    wb_t e;
    guard = 0;
    while (!ex_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({v.name, "_ready"}, {31'b0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_memread = v.rd; ex_memwrite = v.wr; ex_regwrite = v.rw;
    ex_halt = v.halt; ex_wbsel = v.wbsel; ex_wreg = v.wreg; ex_out = v.out;
    ex_wrdata = v.wrdata; ex_pc2 = v.pc2;
    if (!v.exp_err) begin
      e.we = v.exp_we; e.wreg = v.wreg; e.data = v.exp_data;
      exp_q.push_back(e);
    end
    @(negedge clk);
    clear_ex();
    n = 0;
    bad = 0;
    while (mem_en && n < 40) begin
      n++;
      if (mem_addr !== v.out || mem_wr !== v.wr || (v.wr && mem_wdata !== v.wrdata)) bad++;
      mem_done = (n == v.done_at);
      mem_rdata = (n == v.done_at) ? v.rdata : 16'hDEAD;
      @(negedge clk);
    end
    mem_done = 1'b0;
    check({v.name, "_mem_cycles"}, n, v.exp_mem);
    check({v.name, "_mem_stable"}, bad, 0);
    if (v.exp_err) begin
      check({v.name, "_err"}, {28'b0, err, ex_ready, mem_en, wb_valid}, 32'b1000);
      @(negedge clk);
      check({v.name, "_err_sticky"}, {31'b0, err}, 32'd1);
      do_reset();
    end else begin
      // writeback cycle: ready must be low for exactly this cycle
      check({v.name, "_wb_ready_low"}, {30'b0, wb_valid, ex_ready}, 32'b10);
      @(negedge clk);
      #1;
      check({v.name, "_wb_done"}, exp_q.size(), 0);
      if (v.halt) begin
        check({v.name, "_halted"}, {30'b0, halted, ex_ready}, 32'b10);
        ex_valid = 1'b1; ex_regwrite = 1'b1; ex_out = 16'h7777;
        repeat (3) @(negedge clk);
        clear_ex();
        check({v.name, "_halt_hold"}, {29'b0, halted, ex_ready, mem_en}, 32'b100);
        do_reset();
      end else begin
        check({v.name, "_ready_again"}, {31'b0, ex_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(mk("add",       0,0,1,0, 2'b00, 3'd3, 16'h1234, 16'h0, 16'h0,    16'h0,     0, 0, 0, 1, 16'h1234));
    vecs.push_back(mk("add_b2b",   0,0,1,0, 2'b00, 3'd1, 16'h4321, 16'h0, 16'h0,    16'h0,     0, 0, 0, 1, 16'h4321));
    vecs.push_back(mk("load",      1,0,1,0, 2'b01, 3'd5, 16'h0040, 16'h0, 16'h0,    16'hBEEF,  3, 3, 0, 1, 16'hBEEF));
    vecs.push_back(mk("store",     0,1,0,0, 2'b00, 3'd2, 16'h0010, 16'h00FF, 16'h0, 16'h0,     1, 1, 0, 0, 16'h0010));
    vecs.push_back(mk("load_last", 1,0,1,0, 2'b01, 3'd6, 16'h0080, 16'h0, 16'h0,    16'h5A5A, 16,16, 0, 1, 16'h5A5A));
    vecs.push_back(mk("jal",       0,0,1,0, 2'b10, 3'd7, 16'h9999, 16'h0, 16'h0102, 16'h0,     0, 0, 0, 1, 16'h0102));
    vecs.push_back(mk("nowrite",   0,0,0,0, 2'b00, 3'd4, 16'hAAAA, 16'h0, 16'h0,    16'h0,     0, 0, 0, 0, 16'hAAAA));
    vecs.push_back(mk("load_to",   1,0,1,0, 2'b01, 3'd6, 16'h0080, 16'h0, 16'h0,    16'h0,     0,16, 1, 0, 16'h0));
    vecs.push_back(mk("rd_and_wr", 1,1,1,0, 2'b00, 3'd1, 16'h0020, 16'h1, 16'h0,    16'h0,     1, 0, 1, 0, 16'h0));
    vecs.push_back(mk("wbsel11",   0,0,1,0, 2'b11, 3'd1, 16'h0021, 16'h0, 16'h0,    16'h0,     0, 0, 1, 0, 16'h0));
`ifdef MEM_ALIGN_CHECK_EN
    vecs.push_back(mk("load_odd",  1,0,1,0, 2'b01, 3'd3, 16'h0011, 16'h0, 16'h0,    16'h1111,  2, 0, 1, 0, 16'h0));
`else
    vecs.push_back(mk("load_odd",  1,0,1,0, 2'b01, 3'd3, 16'h0011, 16'h0, 16'h0,    16'h1111,  2, 2, 0, 1, 16'h1111));
`endif
    vecs.push_back(mk("jal_halt",  0,0,1,1, 2'b10, 3'd7, 16'h0000, 16'h0, 16'h0102, 16'h0,     0, 0, 0, 1, 16'h0102));
    vecs.push_back(mk("load_halt", 1,0,1,1, 2'b01, 3'd2, 16'h0050, 16'h0, 16'h0,    16'hCAFE,  2, 2, 0, 1, 16'hCAFE));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("init_ex_ready", {31'b0, ex_ready}, 32'd1);
    check("init_outputs", {27'b0, mem_en, mem_wr, wb_valid, halted, err}, 32'd0);
    check("init_wb_payload", {13'b0, wb_reg, wb_data}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset three cycles into a load that never completes.
    ex_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wbsel = 2'b01;
    ex_wreg = 3'd5; ex_out = 16'h0040;
    @(negedge clk);
    clear_ex();
    repeat (2) @(negedge clk);
    check("midacc_mem_en", {31'b0, mem_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midacc_ex_ready", {31'b0, ex_ready}, 32'd1);
    check("midacc_outputs", {27'b0, mem_en, mem_wr, wb_valid, halted, err}, 32'd0);
    check("midacc_wb_payload", {13'b0, wb_reg, wb_data}, 32'd0);
    // stray mem_done in IDLE must not produce anything
    mem_done = 1'b1; mem_rdata = 16'hFACE;
    @(negedge clk);
    mem_done = 1'b0;
    check("stray_done", {28'b0, wb_valid, mem_en, err, ex_ready}, 32'b0001);
    @(negedge clk);
    check("stray_done_wb", {31'b0, wb_valid}, 32'd0);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
